alu_multicycle: RTL and testbench

Parametrised multi-cycle ALU, successor to the team's 16-bit add/sub ALU. Same start/done handshake; adds configurable width, eight operations, carry/zero flags, a busy indicator, and an optional iterative shift-add multiplier. Sits between the register file/operand muxes and the writeback stage. The datapath controller issues one operation at a time.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_multicycle_if.sv | 21 ++
 rtl/alu_shift_add_mul.sv | 43 ++++
 rtl/carry_select_adder.sv | 26 ++
 rtl/alu_multicycle.sv | 124 ++++++++++++
 tb/tb_alu_multicycle.sv | 191 +++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the multi-cycle ALU.
package alu_pkg;
    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;
    localparam alu_op_t ALU_XOR = 3'b100;
    localparam alu_op_t ALU_SLL = 3'b101;
    localparam alu_op_t ALU_SRL = 3'b110;
    localparam alu_op_t ALU_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;
endpackage

// File: rtl/alu_multicycle_if.sv
// Start/done handshake and operand/result bus between the datapath controller and the ALU.
interface alu_multicycle_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    alu_op_t          alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (output a, b, start, alu_op,
                    input  alu_out, carry, zero, busy, done);
    modport slave  (input  a, b, start, alu_op,
                    output alu_out, carry, zero, busy, done);
endinterface

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per step_i cycle.
// prod_o is the accumulator value after the current step, so the caller can retire on the last step.
module alu_shift_add_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign prod_o = acc_d;
    assign last_o = (cnt_q == CW'(WIDTH-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/carry_select_adder.sv
// Carry-select adder: 4-bit blocks precompute both carry-in cases and a mux chain picks one.
module carry_select_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int NBLK = WIDTH / BLK;

    logic [NBLK:0] c;
    assign c[0] = cin_i;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0] s0, s1;
        assign s0 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]};
        assign s1 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
        assign sum_o[g*BLK +: BLK] = c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign c[g+1]              = c[g] ? s1[BLK]     : s0[BLK];
    end

    assign cout_o = c[NBLK];
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, WIDTH-cycle multiply when ALU_MUL_EN is defined.
// Without ALU_MUL_EN, opcode MUL completes in one cycle with a zero result and busy stays low.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_multicycle_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] add_b, sum, res_d, out_q;
    logic [SW-1:0]    shamt;
    logic             is_sub, cout, cry_d, carry_q, zero_q, done_q;

    // Subtract as a + ~b + 1 so the carry-out doubles as the "a >= b" flag.
    assign is_sub = (bus.alu_op == ALU_SUB);
    assign add_b  = is_sub ? ~bus.b : bus.b;
    assign shamt  = bus.b[SW-1:0];

    carry_select_adder #(.WIDTH(WIDTH)) u_add (
        .a_i    (bus.a),
        .b_i    (add_b),
        .cin_i  (is_sub),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_comb begin
        res_d = '0;
        cry_d = 1'b0;
        case (bus.alu_op)
            ALU_ADD, ALU_SUB: begin res_d = sum; cry_d = cout; end
            ALU_AND: res_d = bus.a & bus.b;
            ALU_OR:  res_d = bus.a | bus.b;
            ALU_XOR: res_d = bus.a ^ bus.b;
            ALU_SLL: res_d = bus.a << shamt;
            ALU_SRL: res_d = bus.a >> shamt;
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    alu_state_e         state_q;
    logic               busy_q, mul_load, mul_last;
    logic [2*WIDTH-1:0] prod_d;

    assign mul_load = (state_q == ST_IDLE) && bus.start && (bus.alu_op == ALU_MUL);

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .load_i (mul_load),
        .step_i (state_q == ST_MUL),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .last_o (mul_last),
        .prod_o (prod_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    if (bus.alu_op == ALU_MUL) begin
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                    end else begin
                        out_q   <= res_d;
                        carry_q <= cry_d;
                        zero_q  <= (res_d == '0);
                        done_q  <= 1'b1;
                    end
                end
                ST_MUL: if (mul_last) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    out_q   <= prod_d[WIDTH-1:0];
                    carry_q <= |prod_d[2*WIDTH-1:WIDTH];
                    zero_q  <= (prod_d[WIDTH-1:0] == '0);
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                out_q   <= res_d;
                carry_q <= cry_d;
                zero_q  <= (res_d == '0);
                done_q  <= 1'b1;
            end
        end
    end

    assign bus.busy = 1'b0;
`endif

    assign bus.alu_out = out_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = zero_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench for alu_multicycle (WIDTH=16); multiply checks follow ALU_MUL_EN.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 16;

    typedef struct {
        string        tag;
        logic [W-1:0] out;
        logic         c;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(W)) bus ();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [W-1:0] out, input logic c, input logic z);
        exp_t e;
        e.tag = tag; e.out = out; e.c = c; e.z = z;
        return e;
    endfunction

    // Reference behaviour written straight from the opcode table.
    function automatic exp_t model(input string tag, input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W:0]   s;
        logic [2*W-1:0] p;
        e.tag = tag; e.out = '0; e.c = 1'b0;
        s = '0; p = '0;
        case (op)
            ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; e.out = s[W-1:0]; e.c = s[W]; end
            ALU_SUB: begin e.out = a - b; e.c = (a >= b); end
            ALU_AND: e.out = a & b;
            ALU_OR:  e.out = a | b;
            ALU_XOR: e.out = a ^ b;
            ALU_SLL: e.out = a << b[3:0];
            ALU_SRL: e.out = a >> b[3:0];
            default: begin
`ifdef ALU_MUL_EN
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.out = p[W-1:0];
                e.c = |p[2*W-1:W];
`endif
            end
        endcase
        e.z = (e.out == '0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.done) begin
            if (q.size() == 0) chk("spurious_done", bus.done, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, "_out"},  bus.alu_out, e.out);
                chk({e.tag, "_c"},    bus.carry,   e.c);
                chk({e.tag, "_z"},    bus.zero,    e.z);
                chk({e.tag, "_busy"}, bus.busy,    0);
            end
        end
    endtask

    // One single-cycle op: result at the next edge, then done must drop.
    task automatic one(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        q.push_back(e);
        bus.start = 1'b1; bus.alu_op = op; bus.a = a; bus.b = b;
        tick();
        chk({e.tag, "_pending"}, q.size(), 0);
        q.delete();
        bus.start = 1'b0;
        tick();
        chk({e.tag, "_pulse"}, bus.done, 0);
    endtask

    initial begin
        logic [W-1:0] prev;
        bus.start = 1'b0; bus.alu_op = ALU_ADD; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",  bus.alu_out, 0);
        chk("rst_c",    bus.carry,   0);
        chk("rst_z",    bus.zero,    0);
        chk("rst_busy", bus.busy,    0);
        chk("rst_done", bus.done,    0);
        rst = 1'b0;
        tick();

        one(ALU_ADD, 16'hFFFF, 16'h0001, mk("add_ovf", 16'h0000, 1'b1, 1'b1));
        one(ALU_SUB, 16'h0005, 16'h0007, mk("sub_neg", 16'hFFFE, 1'b0, 1'b0));
        one(ALU_SLL, 16'h0001, 16'h0013, mk("sll_wrap", 16'h0008, 1'b0, 1'b0));
        one(ALU_SUB, 16'h1234, 16'h1234, model("sub_eq", ALU_SUB, 16'h1234, 16'h1234));
        one(ALU_AND, 16'hF0F0, 16'h3C3C, model("and", ALU_AND, 16'hF0F0, 16'h3C3C));
        one(ALU_SRL, 16'h8000, 16'h00FF, model("srl_max", ALU_SRL, 16'h8000, 16'h00FF));
        one(ALU_SLL, 16'hABCD, 16'h000F, model("sll_max", ALU_SLL, 16'hABCD, 16'h000F));
        one(ALU_ADD, 16'h7FFF, 16'h0001, model("add_nc", ALU_ADD, 16'h7FFF, 16'h0001));

        // Back-to-back issue: start held high across three ops.
        q.push_back(model("b2b_add", ALU_ADD, 16'h1234, 16'h1111));
        q.push_back(model("b2b_xor", ALU_XOR, 16'hFFFF, 16'h0F0F));
        q.push_back(model("b2b_or",  ALU_OR,  16'h00A0, 16'h0A00));
        bus.start = 1'b1; bus.alu_op = ALU_ADD; bus.a = 16'h1234; bus.b = 16'h1111;
        tick();
        chk("b2b_done0", bus.done, 1);
        bus.alu_op = ALU_XOR; bus.a = 16'hFFFF; bus.b = 16'h0F0F;
        tick();
        chk("b2b_done1", bus.done, 1);
        bus.alu_op = ALU_OR; bus.a = 16'h00A0; bus.b = 16'h0A00;
        tick();
        chk("b2b_done2", bus.done, 1);
        bus.start = 1'b0;
        chk("b2b_pending", q.size(), 0);
        q.delete();
        tick();
        chk("b2b_pulse", bus.done, 0);

`ifdef ALU_MUL_EN
        q.push_back(mk("mul", 16'h5F90, 1'b1, 1'b0));
        bus.start = 1'b1; bus.alu_op = ALU_MUL; bus.a = 16'd300; bus.b = 16'd300;
        tick();
        chk("mul_busy_e0", bus.busy, 1);
        chk("mul_done_e0", bus.done, 0);
        prev = bus.alu_out;
        for (int i = 1; i < W; i++) begin
            bus.start  = (i == 3);
            bus.alu_op = (i == 3) ? ALU_ADD : ALU_MUL;
            bus.a      = 16'h0BAD ^ W'(i);
            bus.b      = 16'h0001;
            tick();
            chk("mul_busy", bus.busy, 1);
            chk("mul_hold", bus.alu_out, prev);
        end
        bus.start = 1'b0;
        tick();
        chk("mul_busy_end", bus.busy, 0);
        chk("mul_pending", q.size(), 0);
        q.delete();
        tick();
        chk("mul_pulse", bus.done, 0);

        // Reset five cycles into a multiply aborts it with no completion.
        bus.start = 1'b1; bus.alu_op = ALU_MUL; bus.a = 16'd1234; bus.b = 16'd55;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("abort_out",  bus.alu_out, 0);
        chk("abort_c",    bus.carry,   0);
        chk("abort_z",    bus.zero,    0);
        chk("abort_busy", bus.busy,    0);
        chk("abort_done", bus.done,    0);
        #2 rst = 1'b0;
        repeat (2 * W) tick();
        chk("abort_idle", bus.busy, 0);
        one(ALU_ADD, 16'd2, 16'd3, mk("add_post_rst", 16'h0005, 1'b0, 1'b0));
`else
        one(ALU_MUL, 16'd3, 16'd4, mk("mul_off", 16'h0000, 1'b0, 1'b1));
        chk("mul_off_busy", bus.busy, 0);
        prev = bus.alu_out;
        one(ALU_MUL, 16'd300, 16'd300, mk("mul_off_big", 16'h0000, 1'b0, 1'b1));
        chk("mul_off_busy2", bus.busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
